// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops with one-cycle latency, optional shift-add MUL.
// Define ALU_MC_MUL_EN to build the MUL datapath and MUL_RUN state; otherwise opcode 10 is illegal.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_instruction_code,
  input  logic [WIDTH-1:0] acu,
  input  logic [WIDTH-1:0] reg_file,
  output logic             out_valid,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_hi,
  output logic             flag_z,
  output logic             flag_cy,
  output logic             flag_ov,
  output logic             flag_p,
  output logic             flag_s,
  output logic             flag_err
);
  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] OP_NOT = 4'd0, OP_XOR = 4'd1, OP_OR  = 4'd2, OP_AND = 4'd3,
                         OP_SUB = 4'd4, OP_ADD = 4'd5, OP_RR  = 4'd6, OP_RL  = 4'd7,
                         OP_DEC = 4'd8, OP_INC = 4'd9, OP_MUL = 4'd10;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_MC_MUL_EN
  typedef enum logic {IDLE, MUL_RUN} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t state, state_nxt;
  logic acc, is_mul, mul_done;
  logic pend;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;

  assign in_ready = (state == IDLE);
  assign acc      = in_valid & in_ready;
`ifdef ALU_MC_MUL_EN
  assign is_mul   = (alu_instruction_code == OP_MUL);
`else
  assign is_mul   = 1'b0;
`endif

  // Capture stage: single-cycle ops are evaluated one edge after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      pend <= acc & ~is_mul;
      if (acc) begin
        op_q <= alu_instruction_code;
        a_q  <= acu;
        b_q  <= reg_file;
      end
    end
  end

  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   sum;
  logic             cy, ov, illegal;

  always_comb begin
    r       = '0;
    sum     = '0;
    cy      = 1'b0;
    ov      = 1'b0;
    illegal = 1'b0;
    case (op_q)
      OP_NOT: r = ~a_q;
      OP_XOR: r = a_q ^ b_q;
      OP_OR:  r = a_q | b_q;
      OP_AND: r = a_q & b_q;
      OP_SUB: begin
        sum = {1'b0, a_q} - {1'b0, b_q};
        r   = sum[MSB:0];
        cy  = sum[WIDTH];
        ov  = (a_q[MSB] ^ b_q[MSB]) & (r[MSB] ^ a_q[MSB]);
      end
      OP_ADD: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        r   = sum[MSB:0];
        cy  = sum[WIDTH];
        ov  = ~(a_q[MSB] ^ b_q[MSB]) & (r[MSB] ^ a_q[MSB]);
      end
      OP_RR: begin
        r  = a_q >> 1;
        cy = a_q[0];
      end
      OP_RL: begin
        r  = a_q << 1;
        cy = a_q[MSB];
      end
      OP_DEC: begin
        sum = {1'b0, a_q} - ONE;
        r   = sum[MSB:0];
        cy  = sum[WIDTH];
        ov  = a_q[MSB] & ~r[MSB];
      end
      OP_INC: begin
        sum = {1'b0, a_q} + ONE;
        r   = sum[MSB:0];
        cy  = sum[WIDTH];
        ov  = ~a_q[MSB] & r[MSB];
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] m_a, m_hi, m_lo;
  logic [WIDTH:0]   m_sum;
  logic [CW-1:0]    cnt;
  logic             mul_last;

  assign m_sum    = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_a} : '0);
  assign mul_last = (state == MUL_RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && is_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Right-shifting shift-add: {m_hi,m_lo} ends up holding the full product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a      <= '0;
      m_hi     <= '0;
      m_lo     <= '0;
      cnt      <= '0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= mul_last;
      if (acc && is_mul) begin
        m_a  <= acu;
        m_hi <= '0;
        m_lo <= reg_file;
        cnt  <= '0;
      end else if (state == MUL_RUN) begin
        {m_hi, m_lo} <= {m_sum, m_lo[MSB:1]};
        cnt          <= cnt + 1'b1;
      end
    end
  end
`else
  always_comb begin
    state_nxt = IDLE;
  end
  assign mul_done = 1'b0;
  assign data_hi  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data      <= '0;
`ifdef ALU_MC_MUL_EN
      data_hi   <= '0;
`endif
      flag_z    <= 1'b0;
      flag_cy   <= 1'b0;
      flag_ov   <= 1'b0;
      flag_p    <= 1'b0;
      flag_s    <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      out_valid <= pend | mul_done;
`ifdef ALU_MC_MUL_EN
      if (mul_done) begin
        data     <= m_lo;
        data_hi  <= m_hi;
        flag_cy  <= |m_hi;
        flag_ov  <= |m_hi;
        flag_z   <= ~|m_lo;
        flag_p   <= ~^m_lo;
        flag_s   <= m_lo[MSB];
        flag_err <= 1'b0;
      end else
`endif
      if (pend) begin
        if (illegal) begin
          flag_err <= 1'b1;
        end else begin
          data     <= r;
`ifdef ALU_MC_MUL_EN
          data_hi  <= '0;
`endif
          flag_cy  <= cy;
          flag_ov  <= ov;
          flag_z   <= ~|r;
          flag_p   <= ~^r;
          flag_s   <= r[MSB];
          flag_err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8; MUL checks compiled only when ALU_MC_MUL_EN is defined.
module tb_alu_mc;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       out_valid;
  logic [7:0] data, data_hi;
  logic       flag_z, flag_cy, flag_ov, flag_p, flag_s, flag_err;
  int checks = 0;
  int failures = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_instruction_code(op), .acu(a), .reg_file(b),
    .out_valid(out_valid), .data(data), .data_hi(data_hi),
    .flag_z(flag_z), .flag_cy(flag_cy), .flag_ov(flag_ov),
    .flag_p(flag_p), .flag_s(flag_s), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {z,cy,ov,p,s,err}
  task automatic chk_res(input string tag, input logic [7:0] d, input logic [7:0] dh,
                         input logic [5:0] f);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".data_hi"}, 32'(data_hi), 32'(dh));
    chk({tag, ".flags"}, 32'({flag_z, flag_cy, flag_ov, flag_p, flag_s, flag_err}), 32'(f));
  endtask

  task automatic req(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'({data, data_hi}), 32'd0);
    chk("rst.flags", 32'({flag_z, flag_cy, flag_ov, flag_p, flag_s, flag_err}), 32'd0);
    rst = 1'b0;
    chk("rst.ready", 32'(in_ready), 32'd1);

    // ADD 0xFF+0x01 accepted on first edge after release
    req(4'd5, 8'hFF, 8'h01);
    tick();
    in_valid = 1'b0;
    chk("add.lat", 32'(out_valid), 32'd0);
    tick();
    chk_res("add", 8'h00, 8'h00, 6'b110100);
    tick();
    chk("add.pulse", 32'(out_valid), 32'd0);
    chk("add.hold", 32'(data), 32'h00);

    // SUB 0x80-0x01 then INC 0x7F back-to-back
    req(4'd4, 8'h80, 8'h01);
    tick();
    req(4'd9, 8'h7F, 8'h00);
    tick();
    chk_res("sub", 8'h7F, 8'h00, 6'b001000);
    in_valid = 1'b0;
    tick();
    chk_res("inc", 8'h80, 8'h00, 6'b001010);

    // XOR, RR, illegal opcode on consecutive cycles
    req(4'd1, 8'hF0, 8'h3C);
    tick();
    req(4'd6, 8'h03, 8'h00);
    tick();
    chk_res("xor", 8'hCC, 8'h00, 6'b000110);
    req(4'd12, 8'h55, 8'hAA);
    tick();
    chk_res("rr", 8'h01, 8'h00, 6'b010000);
    req(4'd3, 8'h0F, 8'h3C);
    tick();
    chk_res("ill", 8'h01, 8'h00, 6'b010001);
    req(4'd7, 8'h81, 8'h00);
    tick();
    chk_res("and", 8'h0C, 8'h00, 6'b000100);
    req(4'd8, 8'h00, 8'h00);
    tick();
    chk_res("rl", 8'h02, 8'h00, 6'b010000);
    req(4'd0, 8'h5A, 8'h00);
    tick();
    chk_res("dec", 8'hFF, 8'h00, 6'b010110);
    in_valid = 1'b0;
    tick();
    chk_res("not", 8'hA5, 8'h00, 6'b000110);

`ifdef ALU_MC_MUL_EN
    // MUL 0x10*0x20, with a competing request held during the run
    req(4'd10, 8'h10, 8'h20);
    tick();
    req(4'd5, 8'h01, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul.busy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("mul.nov%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    chk("mul.ready", 32'(in_ready), 32'd1);
    chk("mul.early", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk_res("mul", 8'h00, 8'h02, 6'b111100);
    tick();
    chk("mul.noq", 32'(out_valid), 32'd0);

    req(4'd10, 8'h0F, 8'h0F);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("mul2.early", 32'(out_valid), 32'd0);
    tick();
    chk_res("mul2", 8'hE1, 8'h00, 6'b000110);

    // Reset during MUL_RUN aborts the multiply
    req(4'd10, 8'h03, 8'h04);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.data", 32'({data, data_hi}), 32'd0);
    chk("mrst.flags", 32'({flag_z, flag_cy, flag_ov, flag_p, flag_s, flag_err}), 32'd0);
    tick();
    rst = 1'b0;
    chk("mrst.ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    chk("mrst.nopulse", 32'(pulses), 32'd0);
    chk("mrst.hold", 32'(data), 32'h00);
`else
    // Opcode 10 is illegal in this build
    req(4'd10, 8'h02, 8'h03);
    tick();
    in_valid = 1'b0;
    chk("mul.ready", 32'(in_ready), 32'd1);
    tick();
    chk_res("mulx", 8'hA5, 8'h00, 6'b000111);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
